framebuf_dblbuf_param: RTL and testbench

Parametrised, double-buffered (ping-pong) frame buffer for the camera-to-VGA path.
- Writer side takes a raw pixel stream (start-of-frame + valid) and generates write addresses internally.
- Reader side gets random access to the stable "front" frame with a registered read and a valid flag.
- Banks swap only at a reader frame boundary, so the display never shows a torn frame.
- Sits between the camera capture/processing stage and the VGA/object-detect reader.

---
 rtl/framebuf_dblbuf_param_pkg.sv | 16 +
 rtl/framebuf_sdp_ram.sv | 30 +++
 rtl/framebuf_dblbuf_param.sv | 162 ++++++++++++++++
 tb/tb_framebuf_dblbuf_param.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/framebuf_dblbuf_param_pkg.sv
// Shared defaults and writer-state encoding for the ping-pong frame buffer.
package framebuf_dblbuf_param_pkg;

    localparam int C_IMG_COLS_DEF = 80;
    localparam int C_IMG_ROWS_DEF = 60;
    localparam int C_NB_ADDR_DEF  = 13;
    localparam int C_NB_BUF_DEF   = 12;
    localparam int C_NB_DROP_DEF  = 8;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_WRITE = 2'd1,
        WR_SKIP  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/framebuf_sdp_ram.sv
// Simple dual-port RAM with registered read and no reset so it maps onto block RAM.
module framebuf_sdp_ram #(
    parameter int C_WIDTH = 12,
    parameter int C_DEPTH = 1024,
    parameter int C_NB_A  = 10
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [C_NB_A-1:0]  wr_addr,
    input  logic [C_WIDTH-1:0] wr_data,
    input  logic               rd_en,
    input  logic [C_NB_A-1:0]  rd_addr,
    output logic [C_WIDTH-1:0] rd_data
);

    logic [C_WIDTH-1:0] mem_q [C_DEPTH];
    logic [C_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/framebuf_dblbuf_param.sv
// Ping-pong frame buffer: the camera fills the back bank while the reader sees a stable front
// bank; banks swap only on the reader's frame boundary once a complete frame is waiting.
module framebuf_dblbuf_param
    import framebuf_dblbuf_param_pkg::*;
#(
    parameter int C_IMG_COLS = C_IMG_COLS_DEF,
    parameter int C_IMG_ROWS = C_IMG_ROWS_DEF,
    parameter int C_NB_ADDR  = C_NB_ADDR_DEF,
    parameter int C_NB_BUF   = C_NB_BUF_DEF,
    parameter int C_NB_DROP  = C_NB_DROP_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_sof,
    input  logic                 wr_valid,
    input  logic [C_NB_BUF-1:0]  wr_data,
    input  logic                 rd_vsync,
    input  logic                 rd_en,
    input  logic [C_NB_ADDR-1:0] rd_addr,
    output logic [C_NB_BUF-1:0]  rd_data,
    output logic                 rd_valid,
    output logic                 front_bank,
    output logic                 frame_pending,
    output logic                 swap_pulse,
    output logic [C_NB_DROP-1:0] drop_cnt
);

    localparam int C_IMG_PXLS = C_IMG_COLS * C_IMG_ROWS;
    // Physical address is {bank, index}; bank 1 starts at 2^C_NB_ADDR.
    localparam int C_RAM_DEPTH = (1 << C_NB_ADDR) + C_IMG_PXLS;
    localparam logic [C_NB_ADDR-1:0] PXLS_A = C_NB_ADDR'(C_IMG_PXLS);
    localparam logic [C_NB_ADDR-1:0] LAST_A = C_NB_ADDR'(C_IMG_PXLS - 1);

    function automatic logic [C_NB_DROP-1:0] sat_inc(input logic [C_NB_DROP-1:0] v);
        return (&v) ? v : v + C_NB_DROP'(1);
    endfunction

    wr_state_t            state_q, state_d;
    logic [C_NB_ADDR-1:0] cnt_q, cnt_d;
    logic                 front_q, front_d;
    logic                 pend_q, pend_d;
    logic                 swap_q, swap_d;
    logic [C_NB_DROP-1:0] drop_q, drop_d;
    logic                 rd_vld_p1_q, rd_vld_p1_d;
    logic                 rd_zero_p1_q, rd_zero_p1_d;

    logic                 wr_we;
    logic [C_NB_ADDR-1:0] wr_idx;
    logic                 pend_set;
    logic                 drop_inc;
    logic                 do_swap;
    logic                 rd_in_range;
    logic [C_NB_BUF-1:0]  ram_rd_data;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_we    = 1'b0;
        wr_idx   = cnt_q;
        pend_set = 1'b0;
        drop_inc = 1'b0;
        unique case (state_q)
            WR_WRITE: begin
                if (wr_valid && wr_sof) begin
                    wr_we  = 1'b1;
                    wr_idx = '0;
                    cnt_d  = C_NB_ADDR'(1);
                end else if (wr_valid) begin
                    wr_we = 1'b1;
                    if (cnt_q == LAST_A) begin
                        cnt_d    = '0;
                        pend_set = 1'b1;
                        state_d  = WR_IDLE;
                    end else begin
                        cnt_d = cnt_q + C_NB_ADDR'(1);
                    end
                end
            end
            default: begin
                // IDLE and SKIP react identically to a new start of frame.
                if (wr_valid && wr_sof) begin
                    if (!pend_q) begin
                        wr_we   = 1'b1;
                        wr_idx  = '0;
                        cnt_d   = C_NB_ADDR'(1);
                        state_d = WR_WRITE;
                    end else begin
                        drop_inc = 1'b1;
                        state_d  = WR_SKIP;
                    end
                end
            end
        endcase
    end

    always_comb begin
        do_swap = rd_vsync && pend_q;
        front_d = do_swap ? ~front_q : front_q;
        swap_d  = do_swap;
        pend_d  = pend_q;
        if (do_swap) begin
            pend_d = 1'b0;
        end
        if (pend_set) begin
            pend_d = 1'b1;
        end
        drop_d = drop_inc ? sat_inc(drop_q) : drop_q;
    end

    // Read request stage -> registered data stage
    always_comb begin
        rd_in_range  = (rd_addr < PXLS_A);
        rd_vld_p1_d  = rd_en;
        rd_zero_p1_d = rd_en ? ~rd_in_range : rd_zero_p1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WR_IDLE;
            cnt_q        <= '0;
            front_q      <= 1'b0;
            pend_q       <= 1'b0;
            swap_q       <= 1'b0;
            drop_q       <= '0;
            rd_vld_p1_q  <= 1'b0;
            rd_zero_p1_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            front_q      <= front_d;
            pend_q       <= pend_d;
            swap_q       <= swap_d;
            drop_q       <= drop_d;
            rd_vld_p1_q  <= rd_vld_p1_d;
            rd_zero_p1_q <= rd_zero_p1_d;
        end
    end

    framebuf_sdp_ram #(
        .C_WIDTH (C_NB_BUF),
        .C_DEPTH (C_RAM_DEPTH),
        .C_NB_A  (C_NB_ADDR + 1)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_we),
        .wr_addr ({~front_q, wr_idx}),
        .wr_data (wr_data),
        .rd_en   (rd_en && rd_in_range),
        .rd_addr ({front_q, rd_addr}),
        .rd_data (ram_rd_data)
    );

    // The RAM output only updates on in-range reads, so masking with the zero flag
    // gives 0 for out-of-range/reset and holds the last value between requests.
    assign rd_data       = rd_zero_p1_q ? '0 : ram_rd_data;
    assign rd_valid      = rd_vld_p1_q;
    assign front_bank    = front_q;
    assign frame_pending = pend_q;
    assign swap_pulse    = swap_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_framebuf_dblbuf_param.sv
// Directed bench for the ping-pong frame buffer: fill, swap, drop, abort, boundary reads, reset.
module tb_framebuf_dblbuf_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_sof;
    logic        wr_valid;
    logic [11:0] wr_data;
    logic        rd_vsync;
    logic        rd_en;
    logic [12:0] rd_addr;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic        front_bank;
    logic        frame_pending;
    logic        swap_pulse;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    framebuf_dblbuf_param #(
        .C_IMG_COLS (80),
        .C_IMG_ROWS (60),
        .C_NB_ADDR  (13),
        .C_NB_BUF   (12),
        .C_NB_DROP  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_sof        (wr_sof),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .rd_vsync      (rd_vsync),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .front_bank    (front_bank),
        .frame_pending (frame_pending),
        .swap_pulse    (swap_pulse),
        .drop_cnt      (drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_pix(input int start, input int n, input logic use_idx, input logic [11:0] cval);
        for (int i = start; i < start + n; i++) begin
            wr_valid = 1'b1;
            wr_sof   = (i == 0);
            wr_data  = use_idx ? i[11:0] : cval;
            tick();
        end
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [12:0] a, input logic [11:0] e);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
        chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
        chk(tag, 32'(rd_data), 32'(e));
    endtask

    task automatic vsync();
        rd_vsync = 1'b1;
        tick();
        rd_vsync = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_sof = 1'b0; wr_valid = 1'b0; wr_data = '0;
        rd_vsync = 1'b0; rd_en = 1'b0; rd_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_front", 32'(front_bank), 32'd0);
        chk("rst_pending", 32'(frame_pending), 32'd0);
        chk("rst_swap", 32'(swap_pulse), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);

        // 1: index-pattern frame into bank 1, swap, read back
        send_pix(0, 4800, 1'b1, 12'h000);
        chk("t1_pending", 32'(frame_pending), 32'd1);
        vsync();
        chk("t1_swap", 32'(swap_pulse), 32'd1);
        chk("t1_front", 32'(front_bank), 32'd1);
        chk("t1_pend_clr", 32'(frame_pending), 32'd0);
        tick();
        chk("t1_swap_once", 32'(swap_pulse), 32'd0);
        rd_chk("t1_rd0", 13'd0, 12'h000);
        rd_chk("t1_rd79", 13'd79, 12'h04F);
        rd_chk("t1_rd4799", 13'd4799, 12'h2BF);

        // 2: frame A completes, frame B is dropped while A waits
        send_pix(0, 4800, 1'b0, 12'h111);
        chk("t2_pendA", 32'(frame_pending), 32'd1);
        send_pix(0, 4800, 1'b0, 12'h222);
        chk("t2_drop", 32'(drop_cnt), 32'd1);
        chk("t2_pend_kept", 32'(frame_pending), 32'd1);
        vsync();
        chk("t2_front", 32'(front_bank), 32'd0);
        rd_chk("t2_rd0", 13'd0, 12'h111);
        rd_chk("t2_rd100", 13'd100, 12'h111);
        rd_chk("t2_rd4799", 13'd4799, 12'h111);

        // 3: aborted frame after 100 pixels, then a full 0xABC frame
        send_pix(0, 100, 1'b0, 12'h555);
        chk("t3_pend_abort", 32'(frame_pending), 32'd0);
        send_pix(0, 4799, 1'b0, 12'hABC);
        chk("t3_pend_4799", 32'(frame_pending), 32'd0);
        send_pix(4799, 1, 1'b0, 12'hABC);
        chk("t3_pend_full", 32'(frame_pending), 32'd1);
        vsync();
        chk("t3_front", 32'(front_bank), 32'd1);
        rd_chk("t3_rd0", 13'd0, 12'hABC);
        rd_chk("t3_rd99", 13'd99, 12'hABC);
        rd_chk("t3_rd100", 13'd100, 12'hABC);
        rd_chk("t3_rd2500", 13'd2500, 12'hABC);
        rd_chk("t3_rd4799", 13'd4799, 12'hABC);

        // 4: vsync on the same cycle as the last write does not swap
        send_pix(0, 4799, 1'b0, 12'h333);
        wr_valid = 1'b1; wr_sof = 1'b0; wr_data = 12'h333; rd_vsync = 1'b1;
        tick();
        wr_valid = 1'b0; rd_vsync = 1'b0;
        chk("t4_noswap", 32'(swap_pulse), 32'd0);
        chk("t4_front_kept", 32'(front_bank), 32'd1);
        chk("t4_pending", 32'(frame_pending), 32'd1);
        tick(); tick(); tick(); tick();
        vsync();
        chk("t4_swap", 32'(swap_pulse), 32'd1);
        chk("t4_front", 32'(front_bank), 32'd0);
        rd_chk("t4_rd4799", 13'd4799, 12'h333);

        // 5: hold between reads, out-of-range address
        rd_chk("t5_rd10", 13'd10, 12'h333);
        tick();
        chk("t5_idle_vld", 32'(rd_valid), 32'd0);
        chk("t5_hold", 32'(rd_data), 32'h333);
        rd_chk("t5_oob", 13'd4800, 12'h000);
        tick();
        chk("t5_oob_idle_vld", 32'(rd_valid), 32'd0);
        chk("t5_oob_hold", 32'(rd_data), 32'd0);

        // 6: reset in the middle of a frame, then a clean frame
        rd_chk("t6_pre_rd", 13'd5, 12'h333);
        send_pix(0, 2000, 1'b0, 12'h777);
        rst = 1'b1; rd_en = 1'b1; rd_addr = 13'd5;
        tick();
        rst = 1'b0; rd_en = 1'b0;
        chk("t6_rd_data", 32'(rd_data), 32'd0);
        chk("t6_rd_valid", 32'(rd_valid), 32'd0);
        chk("t6_front", 32'(front_bank), 32'd0);
        chk("t6_pending", 32'(frame_pending), 32'd0);
        chk("t6_drop", 32'(drop_cnt), 32'd0);
        chk("t6_swap", 32'(swap_pulse), 32'd0);
        send_pix(0, 4800, 1'b1, 12'h000);
        chk("t6_pend_full", 32'(frame_pending), 32'd1);
        vsync();
        chk("t6_swapped", 32'(swap_pulse), 32'd1);
        chk("t6_front1", 32'(front_bank), 32'd1);
        rd_chk("t6_rd4000", 13'd4000, 12'hFA0);
        rd_chk("t6_rd2000", 13'd2000, 12'h7D0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
